pattern_detector: RTL
=====================

// Module: pattern_detector
// PURPOSE
//   Serial-to-parallel receiver and sequence detector for the pattern generator's bit stream.
//   Samples one serial bit per enabled clock and keeps a sliding window of the last PAT_W bits.
//   Pulses match when the window equals PATTERN, and keeps a saturating count of matches.
//   Sits at the receive end of the serial pattern link, fed directly by the generator's out.
// PARAMETERS
//   PAT_W    5         pattern length in bits; legal range 2..32
//   PATTERN  5'b10011  target sequence, declared [0:PAT_W-1]; bit [0] is the first bit on the wire
//   OVERLAP  1         1: matches may share bits; 0: window refills from empty after each match
//   CNT_W    8         width of match_count
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous reset, active-low (reset==0 resets on the next clk edge)
//   in_valid     in   1      in_bit is sampled on this edge only when in_valid==1
//   in_bit       in   1      serial data, first-on-wire bit first
//   cnt_clr      in   1      synchronous clear of match_count
//   window       out  PAT_W  last PAT_W accepted bits, declared [0:PAT_W-1]; [0] is the oldest
//   armed        out  1      1 once PAT_W bits have been accepted since the last reset or refill
//   match        out  1      one-cycle pulse; window==PATTERN with armed
//   match_count  out  CNT_W  number of matches, saturating at 2**CNT_W-1
// BEHAVIOUR
//   Reset (reset==0 at a clk edge) drives window=0, armed=0, match=0, match_count=0, fill=0, state=FILL.
//   Reset has priority over every other input and aborts a partial sequence at any point.
//   Accept: a clk edge with reset==1 and in_valid==1.
//     - window <= {window[1:PAT_W-1], in_bit}.
//   No accept (in_valid==0): window, fill and state hold, and match<=0. Gaps never break a sequence.
//   FSM, 2 states:
//     FILL: fill counter (width clog2(PAT_W+1)) increments on each accept.
//           The accept that takes fill to PAT_W moves the FSM to HUNT and sets armed<=1 on the same edge.
//     HUNT: fill held at PAT_W; armed=1.
//   Match: on an accepting edge, next-window==PATTERN and (state==HUNT or the accept completes FILL)
//          gives match<=1; otherwise match<=0.
//     - Latency: match is high for the one cycle after the edge that accepts the last pattern bit.
//   OVERLAP==0: the matching accept also sets fill<=0, armed<=0, state<=FILL.
//     - window still loads the new bit, but no match is possible until PAT_W further bits arrive.
//   OVERLAP==1: the FSM stays in HUNT, so consecutive matches may be spaced by the pattern period.
//   match_count: increments when match is set, unless it is already all-ones (saturates, no wrap).
//     - cnt_clr==1 forces match_count<=0 and takes priority over a simultaneous increment.
//     - match still pulses normally in that cycle.
//   Invalid data: in_bit X/Z is never accepted when in_valid==0. All outputs are registered.
// TESTING
//   1 Defaults; hold reset low for 2 clocks, then feed bits 1,0,0,1,1 with in_valid=1
//     -> match high exactly 1 cycle after the 5th bit; match_count=1; window=5'b10011.
//   2 Defaults; feed 1,0,0,1,1 with in_valid=0 for 3 cycles between bits 2 and 3
//     -> exactly one match, 1 cycle after the 5th accepted bit.
//   3 PATTERN=5'b10101, OVERLAP=1; feed 1,0,1,0,1,0,1 -> match after the 5th and 7th bits; count=2.
//     Same stream with OVERLAP=0 -> match after the 5th bit only; count=1; armed=0 after the 5th bit.
//   4 Defaults; feed 1,0,0, then pull reset low for 1 cycle, then feed 1,1
//     -> no match; armed=0; window=5'b00011.
//   5 CNT_W=2; feed the pattern 5 times back-to-back -> match_count goes 1,2,3,3,3.
//     Then assert cnt_clr for 1 cycle -> count=0.
//   6 Defaults; feed 1,0,0,1 -> armed stays 0 and match stays 0 until a 5th bit is accepted.

Source files
------------

// File: rtl/pattern_detector_if.sv
// pattern_detector_if: serial input and detector status bundle for the pattern link receiver.
interface pattern_detector_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             cnt_clr;
    logic [0:PAT_W-1] window;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] match_count;
    modport master (
        output in_valid, in_bit, cnt_clr,
        input  window, armed, match, match_count
    );
    modport slave (
        input  in_valid, in_bit, cnt_clr,
        output window, armed, match, match_count
    );
endinterface

// File: rtl/pattern_detector.sv
// pattern_detector: sliding-window serial sequence detector with a saturating match counter.
module pattern_detector #(
    parameter int               PAT_W   = 5,
    parameter logic [0:PAT_W-1] PATTERN = 5'b10011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input logic              clk,
    input logic              reset,
    pattern_detector_if.slave bus
);
    localparam int              FW   = $clog2(PAT_W + 1);
    localparam logic [0:0]      FILL = 1'b0;
    localparam logic [0:0]      HUNT = 1'b1;
    localparam logic [FW-1:0]   LAST = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [0:PAT_W-1] window_q, window_d, win_nxt;
    logic [FW-1:0]    fill_q, fill_d;
    logic [0:0]       state_q, state_d;
    logic             armed_q, armed_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fill_done, hit;

    always_comb begin
        win_nxt   = {window_q[1:PAT_W-1], bus.in_bit};
        fill_done = state_q == FILL && fill_q == LAST;
        hit       = bus.in_valid && win_nxt == PATTERN && (state_q == HUNT || fill_done);
        window_d  = bus.in_valid ? win_nxt : window_q;
        fill_d    = fill_q;
        state_d   = state_q;
        armed_d   = armed_q;
        if (bus.in_valid && state_q == FILL)
            fill_d = fill_q + 1'b1;
        if (bus.in_valid && fill_done) begin
            state_d = HUNT;
            armed_d = 1'b1;
        end
        // Non-overlapping mode discards the matched bits from the fill count.
        if (hit && !OVERLAP) begin
            fill_d  = '0;
            state_d = FILL;
            armed_d = 1'b0;
        end
        match_d = hit;
        count_d = bus.cnt_clr ? '0 : (hit && count_q != CMAX) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            window_q <= '0;
            fill_q   <= '0;
            state_q  <= FILL;
            armed_q  <= 1'b0;
            match_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            state_q  <= state_d;
            armed_q  <= armed_d;
            match_q  <= match_d;
            count_q  <= count_d;
        end
    end

    assign bus.window      = window_q;
    assign bus.armed       = armed_q;
    assign bus.match       = match_q;
    assign bus.match_count = count_q;
endmodule
